// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue.
// Issues sequential fetches to a one-cycle-latency instruction memory and
// buffers the returned words with their PCs in a small FIFO for decode.
// Issue is gated by credit: count plus any response in flight.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic [WIDTH-1:0]         imem_data,
  output logic [WIDTH-1:0]         ir,
  output logic [WIDTH-1:0]         ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] ir_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_q [DEPTH];

  logic [CW:0]      used;
  logic             push;
  logic             pop;
  logic             head_valid;

  // Credit check and output decode; outputs are forced to zero while reset is low.
  always_comb begin
    used       = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
    imem_req   = reset && !halt && !redirect && (used < (CW+1)'(DEPTH));
    head_valid = (count_q != '0);
    ir_valid   = reset && head_valid;
    ir         = ir_valid ? ir_mem_q[rd_ptr_q] : '0;
    ir_pc      = ir_valid ? pc_mem_q[rd_ptr_q] : '0;
    imem_addr  = reset ? fetch_pc_q : '0;
    count      = reset ? count_q : '0;
    push       = pend_q && !redirect;
    pop        = ir_valid && ir_ready;
  end

  // Next-state: redirect clears the FIFO and drops the response arriving this cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = imem_req;
    pend_pc_d  = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      pend_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + WIDTH'(1);
      if (push)     wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d   = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: capture the memory response with the PC that requested it.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ir_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q] <= pend_pc_q;
    end
  end

endmodule
